uart_tx_arbiter: RTL and testbench

//  Shares one UART_Tx byte transmitter between N_REQ requesters using round-robin arbitration.

---
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_Tx byte transmitter between N_REQ requesters.
// Latches the winner's byte, pulses start, then follows the transmitter's busy flag to frame end.
module uart_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int START_TO = 15
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  output logic [N_REQ-1:0]        ack_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [DATA_W-1:0]       tx_data_o,
  output logic                    tx_start_o,
  input  logic                    tx_busy_i
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(START_TO + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO, DONE} state_t;

  state_t             state, state_n;
  logic [PTR_W-1:0]   rr_ptr, rr_n;
  logic [CNT_W-1:0]   to_cnt, cnt_n;
  logic [N_REQ-1:0]   ack_n, grant_n;
  logic               done_n, err_n, start_n;
  logic [DATA_W-1:0]  data_n;
  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W:0]     cand;

  // Scan from the requester after the last winner, wrapping, so the last winner ranks lowest.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_REQ))
        cand = cand - (PTR_W+1)'(N_REQ);
      if (!pick_found && req_i[cand[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    cnt_n   = to_cnt;
    ack_n   = '0;
    grant_n = grant_o;
    done_n  = 1'b0;
    err_n   = 1'b0;
    start_n = 1'b0;
    data_n  = tx_data_o;
    case (state)
      IDLE: begin
        grant_n = '0;
        if (pick_found && !tx_busy_i) begin
          state_n = LAUNCH;
          grant_n = N_REQ'(1) << pick_idx;
          ack_n   = N_REQ'(1) << pick_idx;
          start_n = 1'b1;
          data_n  = data_i[pick_idx*DATA_W +: DATA_W];
          rr_n    = pick_idx;
        end
      end
      LAUNCH: begin
        state_n = WAIT_HI;
        cnt_n   = '0;
      end
      WAIT_HI: begin
        if (tx_busy_i) begin
          state_n = WAIT_LO;
        end else if (to_cnt == CNT_W'(START_TO - 1)) begin
          // Transmitter never acknowledged the start: the byte is dropped, no retry.
          state_n = IDLE;
          err_n   = 1'b1;
          grant_n = '0;
        end else if (to_cnt < CNT_W'(START_TO)) begin
          cnt_n = to_cnt + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!tx_busy_i) begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        grant_n = '0;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      rr_ptr     <= PTR_W'(N_REQ - 1);
      to_cnt     <= '0;
      ack_o      <= '0;
      grant_o    <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      tx_start_o <= 1'b0;
      tx_data_o  <= '0;
    end else begin
      state      <= state_n;
      rr_ptr     <= rr_n;
      to_cnt     <= cnt_n;
      ack_o      <= ack_n;
      grant_o    <= grant_n;
      done_o     <= done_n;
      err_o      <= err_n;
      tx_start_o <= start_n;
      tx_data_o  <= data_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART_Tx busy model
// (busy rises 2 cycles after start, stays high 20 cycles).
module tb_uart_tx_arbiter;

  logic        CLK;
  logic        RST_N;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic [3:0]  ack_o;
  logic [3:0]  grant_o;
  logic        done_o;
  logic        err_o;
  logic [7:0]  tx_data_o;
  logic        tx_start_o;
  logic        tx_busy_i;

  logic        model_en;
  logic        stray_busy;
  logic        model_busy;
  int          model_dly;
  int          model_hold;
  int          checks;
  int          errors;

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .START_TO(15)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .req_i(req_i),
    .data_i(data_i),
    .ack_o(ack_o),
    .grant_o(grant_o),
    .done_o(done_o),
    .err_o(err_o),
    .tx_data_o(tx_data_o),
    .tx_start_o(tx_start_o),
    .tx_busy_i(tx_busy_i)
  );

  always #5 CLK = ~CLK;

  // Transmitter stand-in: shares RST_N, so a reset also kills any frame in flight.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      model_busy <= 1'b0;
      model_dly  <= 0;
      model_hold <= 0;
    end else begin
      if (model_dly > 0) begin
        model_dly <= model_dly - 1;
        if (model_dly == 1) begin
          model_busy <= 1'b1;
          model_hold <= 20;
        end
      end else if (model_hold > 0) begin
        model_hold <= model_hold - 1;
        if (model_hold == 1) model_busy <= 1'b0;
      end
      if (tx_start_o && model_en) model_dly <= 1;
    end
  end

  assign tx_busy_i = model_busy | stray_busy;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [31:0] data);
    req_i  = req;
    data_i = data;
  endtask

  task automatic resetDut();
    RST_N = 1'b0;
    req_i = '0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  // Waits (bounded) for the next ack pulse and checks the grant that comes with it.
  task automatic waitGrant(input string tag, input logic [3:0] exp_grant, input logic [7:0] exp_data);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (ack_o == 4'b0 && n < 50);
    checkOutput({tag, "_ack"},   32'(ack_o),      32'(exp_grant));
    checkOutput({tag, "_grant"}, 32'(grant_o),    32'(exp_grant));
    checkOutput({tag, "_start"}, 32'(tx_start_o), 32'd1);
    checkOutput({tag, "_data"},  32'(tx_data_o),  32'(exp_data));
  endtask

  // Waits (bounded) for done, then checks it is a single pulse and the grant is released.
  task automatic waitDone(input string tag, input logic [3:0] exp_grant);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!done_o && n < 80);
    checkOutput({tag, "_done"},       32'(done_o),  32'd1);
    checkOutput({tag, "_done_grant"}, 32'(grant_o), 32'(exp_grant));
    checkOutput({tag, "_done_err"},   32'(err_o),   32'd0);
    @(negedge CLK);
    checkOutput({tag, "_done_clr"},   32'(done_o),  32'd0);
    checkOutput({tag, "_grant_clr"},  32'(grant_o), 32'd0);
  endtask

  logic [3:0] t2_order [5];
  logic       saw_ack;

  initial begin
    CLK        = 1'b0;
    RST_N      = 1'b0;
    req_i      = '0;
    data_i     = '0;
    model_en   = 1'b1;
    stray_busy = 1'b0;
    checks     = 0;
    errors     = 0;

    @(negedge CLK);
    checkOutput("rst_ack",   32'(ack_o),      32'd0);
    checkOutput("rst_grant", 32'(grant_o),    32'd0);
    checkOutput("rst_done",  32'(done_o),     32'd0);
    checkOutput("rst_err",   32'(err_o),      32'd0);
    checkOutput("rst_start", 32'(tx_start_o), 32'd0);
    checkOutput("rst_data",  32'(tx_data_o),  32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    // T1: single request, one-cycle latency to ack/start
    applyStimulus(4'b0001, 32'h0000_00AA);
    @(negedge CLK);
    checkOutput("t1_ack",   32'(ack_o),      32'h1);
    checkOutput("t1_start", 32'(tx_start_o), 32'd1);
    checkOutput("t1_data",  32'(tx_data_o),  32'hAA);
    checkOutput("t1_grant", 32'(grant_o),    32'h1);
    applyStimulus(4'b0000, 32'h0000_00AA);
    @(negedge CLK);
    checkOutput("t1_start_pulse", 32'(tx_start_o), 32'd0);
    checkOutput("t1_ack_pulse",   32'(ack_o),      32'd0);
    waitDone("t1", 4'b0001);

    // T2: all four held high from a fresh reset -> 0,1,2,3,0
    resetDut();
    t2_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    applyStimulus(4'b1111, 32'h4332_2110);
    for (int k = 0; k < 5; k++) begin
      logic [7:0] exp_byte;
      case (t2_order[k])
        4'b0001: exp_byte = 8'h10;
        4'b0010: exp_byte = 8'h21;
        4'b0100: exp_byte = 8'h32;
        default: exp_byte = 8'h43;
      endcase
      waitGrant($sformatf("t2_%0d", k), t2_order[k], exp_byte);
      waitDone($sformatf("t2_%0d", k), t2_order[k]);
    end
    applyStimulus(4'b0000, 32'h4332_2110);

    // T3: after serving 2, simultaneous 0 and 2 -> 0 first
    applyStimulus(4'b0100, 32'h4332_2110);
    waitGrant("t3_pre", 4'b0100, 8'h32);
    applyStimulus(4'b0000, 32'h4332_2110);
    waitDone("t3_pre", 4'b0100);
    applyStimulus(4'b0101, 32'h4332_2110);
    waitGrant("t3_first", 4'b0001, 8'h10);
    applyStimulus(4'b0100, 32'h4332_2110);
    waitDone("t3_first", 4'b0001);
    waitGrant("t3_second", 4'b0100, 8'h32);
    applyStimulus(4'b0000, 32'h4332_2110);
    waitDone("t3_second", 4'b0100);

    // T4: busy never rises -> err 15 cycles after start drops, then pending request served
    model_en = 1'b0;
    applyStimulus(4'b1010, 32'h4332_2110);
    waitGrant("t4", 4'b1000, 8'h43);
    applyStimulus(4'b0010, 32'h4332_2110);
    @(negedge CLK);
    checkOutput("t4_start_low", 32'(tx_start_o), 32'd0);
    repeat (14) @(negedge CLK);
    checkOutput("t4_err_early", 32'(err_o), 32'd0);
    @(negedge CLK);
    checkOutput("t4_err",   32'(err_o),   32'd1);
    checkOutput("t4_grant", 32'(grant_o), 32'd0);
    checkOutput("t4_done",  32'(done_o),  32'd0);
    model_en = 1'b1;
    waitGrant("t4_next", 4'b0010, 8'h21);
    checkOutput("t4_err_pulse", 32'(err_o), 32'd0);
    applyStimulus(4'b0000, 32'h4332_2110);
    waitDone("t4_next", 4'b0010);

    // T5: reset while the frame is shifting
    applyStimulus(4'b0001, 32'h4332_2110);
    waitGrant("t5", 4'b0001, 8'h10);
    applyStimulus(4'b0000, 32'h4332_2110);
    for (int n = 0; n < 10 && !tx_busy_i; n++) @(negedge CLK);
    repeat (3) @(negedge CLK);
    checkOutput("t5_busy_seen", 32'(tx_busy_i), 32'd1);
    applyStimulus(4'b0110, 32'h4332_2110);
    RST_N = 1'b0;
    #1;
    checkOutput("t5_rst_grant", 32'(grant_o),    32'd0);
    checkOutput("t5_rst_data",  32'(tx_data_o),  32'd0);
    checkOutput("t5_rst_flags", 32'({ack_o, done_o, err_o, tx_start_o}), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    waitGrant("t5_after", 4'b0010, 8'h21);
    applyStimulus(4'b0000, 32'h4332_2110);
    waitDone("t5_after", 4'b0010);

    // T6: stray busy in IDLE blocks the grant until it drops
    stray_busy = 1'b1;
    applyStimulus(4'b0010, 32'h4332_2110);
    saw_ack = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (ack_o != 4'b0) saw_ack = 1'b1;
    end
    checkOutput("t6_no_ack", 32'(saw_ack), 32'd0);
    stray_busy = 1'b0;
    waitGrant("t6", 4'b0010, 8'h21);
    applyStimulus(4'b0000, 32'h4332_2110);
    waitDone("t6", 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
